cpu_control_fsm: RTL and testbench

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

---
 rtl/cpu_control_fsm.sv | 170 +++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control FSM for an 8-bit accumulator CPU.
// Sequences fetch/decode/memory/execute with a bounded memory wait.
module cpu_control_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  input  logic       flag_z,
  input  logic       flag_c,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic [3:0] operand,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic       acc_src,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       fault,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEM_RD = 4'd3,
    S_EXEC   = 4'd4,
    S_STORE  = 4'd5,
    S_HALT   = 4'd6,
    S_FAULT  = 4'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [7:0] wcnt_inc;
  logic [3:0] opc;
  state_t     cont;
  logic       in_acc;

  assign opc      = ir_q[7:4];
  assign wcnt_inc = wcnt_q + 8'd1;
  assign cont     = run ? S_FETCH : S_IDLE;
  assign in_acc   = (state_q == S_FETCH) ||
                    (state_q == S_MEM_RD) ||
                    (state_q == S_STORE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (opc)
          OP_LDA, OP_ADD, OP_SUB,
          OP_AND, OP_OR, OP_XOR:  state_d = S_MEM_RD;
          OP_STA:                 state_d = S_STORE;
          OP_LDI, OP_JMP,
          OP_JZ, OP_JC:           state_d = S_EXEC;
          OP_HLT:                 state_d = S_HALT;
          default:                state_d = cont;
        endcase
      end
      S_MEM_RD: if (mem_ack) state_d = cont;
      S_STORE:  if (mem_ack) state_d = cont;
      S_EXEC:   state_d = cont;
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
    // Ack on the terminal wait cycle still completes the access.
    if (in_acc && !mem_ack) begin
      if (wcnt_inc == TMO) state_d = S_FAULT;
      else                 wcnt_d  = wcnt_inc;
    end
    if (state_d != state_q) wcnt_d = '0;
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_load  = 1'b0;
    acc_src   = 1'b0;
    alu_op    = 3'd0;
    operand   = ir_q[3:0];
    state_dbg = state_q;
    halted    = (state_q == S_HALT);
    fault     = (state_q == S_FAULT);
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        pc_inc  = mem_ack;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        acc_load = mem_ack;
        unique case (opc)
          OP_ADD:  alu_op = 3'd1;
          OP_SUB:  alu_op = 3'd2;
          OP_AND:  alu_op = 3'd3;
          OP_OR:   alu_op = 3'd4;
          OP_XOR:  alu_op = 3'd5;
          default: alu_op = 3'd0;
        endcase
      end
      S_STORE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_sel = 1'b1;
      end
      S_EXEC: begin
        unique case (opc)
          OP_LDI: begin
            acc_load = 1'b1;
            acc_src  = 1'b1;
          end
          OP_JMP:  pc_load = 1'b1;
          OP_JZ:   pc_load = flag_z;
          OP_JC:   pc_load = flag_c;
          default: pc_load = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm.
// One task per scenario, inline checks against hand-derived values.
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       flag_z;
  logic       flag_c;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic [3:0] operand;
  logic       pc_inc;
  logic       pc_load;
  logic       acc_load;
  logic       acc_src;
  logic [2:0] alu_op;
  logic       halted;
  logic       fault;
  logic [3:0] state_dbg;

  int tests = 0;
  int fails = 0;

  cpu_control_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flag_z(flag_z), .flag_c(flag_c),
    .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .operand(operand),
    .pc_inc(pc_inc), .pc_load(pc_load),
    .acc_load(acc_load), .acc_src(acc_src),
    .alu_op(alu_op), .halted(halted),
    .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0;
    mem_rdata = 8'h00; flag_z = 1'b0; flag_c = 1'b0;
    #1;
    tests++;
    if (state_dbg !== 4'd0) begin
      $display("FAIL reset_state got %0d exp 0", state_dbg); fails++;
    end
    tests++;
    if ({mem_req, pc_inc, pc_load, acc_load} !== 4'b0) begin
      $display("FAIL reset_strobes got %b exp 0000",
               {mem_req, pc_inc, pc_load, acc_load}); fails++;
    end
    tests++;
    if ({halted, fault, operand} !== 6'b0) begin
      $display("FAIL reset_status got %b exp 0",
               {halted, fault, operand}); fails++;
    end
    tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_ldi;
    run = 1'b1;
    #1;
    tests++;
    if (state_dbg !== 4'd0) begin
      $display("FAIL ldi_idle got %0d exp 0", state_dbg); fails++;
    end
    tick;
    mem_ack = 1'b1; mem_rdata = 8'h85;
    #1;
    tests++;
    if ({state_dbg, mem_req, pc_inc, addr_sel, mem_we} !== 8'b0001_1100) begin
      $display("FAIL ldi_fetch got %b exp 00011100",
               {state_dbg, mem_req, pc_inc, addr_sel, mem_we}); fails++;
    end
    tick;
    mem_ack = 1'b0;
    #1;
    tests++;
    if ({state_dbg, operand, pc_inc} !== 9'b0010_0101_0) begin
      $display("FAIL ldi_decode got %b exp 001001010",
               {state_dbg, operand, pc_inc}); fails++;
    end
    tick;
    tests++;
    if ({state_dbg, acc_load, acc_src, pc_load} !== 7'b0100_110) begin
      $display("FAIL ldi_exec got %b exp 0100110",
               {state_dbg, acc_load, acc_src, pc_load}); fails++;
    end
    tick;
    tests++;
    if ({state_dbg, acc_load} !== 5'b0001_0) begin
      $display("FAIL ldi_refetch got %b exp 00010",
               {state_dbg, acc_load}); fails++;
    end
  endtask

  task automatic test_mem_rd;
    int nreq;
    nreq = 0;
    mem_ack = 1'b1; mem_rdata = 8'h37;
    tick;
    mem_ack = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #1;
      if (mem_req) nreq++;
      tests++;
      if ({state_dbg, addr_sel, mem_we, operand} !== 10'b0011_10_0111 ||
          acc_load !== (i == 3)) begin
        $display("FAIL mem_rd_cyc%0d got st=%0d as=%b we=%b op=%0h ld=%b",
                 i, state_dbg, addr_sel, mem_we, operand, acc_load);
        fails++;
      end
      if (i == 3) begin
        tests++;
        if ({alu_op, acc_src} !== 4'b001_0) begin
          $display("FAIL mem_rd_alu got op=%0d src=%b exp op=1 src=0",
                   alu_op, acc_src); fails++;
        end
      end
      tick;
    end
    mem_ack = 1'b0;
    #1;
    tests++;
    if (nreq !== 4 || state_dbg !== 4'd1) begin
      $display("FAIL mem_rd_done got req=%0d st=%0d exp req=4 st=1",
               nreq, state_dbg); fails++;
    end
  endtask

  task automatic test_jz;
    for (int p = 0; p < 2; p++) begin
      flag_z = (p == 1);
      mem_ack = 1'b1; mem_rdata = 8'hA3;
      tick;
      mem_ack = 1'b0;
      tick;
      tests++;
      if ({state_dbg, pc_load, pc_inc, acc_load} !== {4'd4, (p == 1), 2'b00}) begin
        $display("FAIL jz_exec_z%0d got st=%0d ld=%b exp st=4 ld=%0d",
                 p, state_dbg, pc_load, p); fails++;
      end
      tick;
      tests++;
      if ({state_dbg, pc_load} !== 5'b0001_0) begin
        $display("FAIL jz_after_z%0d got st=%0d ld=%b exp st=1 ld=0",
                 p, state_dbg, pc_load); fails++;
      end
    end
    flag_z = 1'b0;
  endtask

  task automatic test_run_drop;
    mem_ack = 1'b1; mem_rdata = 8'h37;
    tick;
    mem_ack = 1'b0; run = 1'b0;
    tick;
    tests++;
    if (state_dbg !== 4'd3) begin
      $display("FAIL run_drop_mem_rd got %0d exp 3", state_dbg); fails++;
    end
    tick;
    mem_ack = 1'b1;
    #1;
    tests++;
    if (acc_load !== 1'b1) begin
      $display("FAIL run_drop_load got %b exp 1", acc_load); fails++;
    end
    tick;
    mem_ack = 1'b0;
    #1;
    tests++;
    if ({state_dbg, mem_req} !== 5'b0000_0) begin
      $display("FAIL run_drop_idle got st=%0d req=%b exp 0 0",
               state_dbg, mem_req); fails++;
    end
    run = 1'b1;
    tick;
  endtask

  task automatic test_ack_boundary;
    int bad;
    bad = 0;
    mem_ack = 1'b1; mem_rdata = 8'h2C;
    tick;
    tick;
    for (int i = 0; i < 15; i++) begin
      mem_ack = (i == 14);
      #1;
      if ({state_dbg, mem_req, mem_we, addr_sel, acc_load} !== 8'b0101_1110)
        bad++;
      tick;
    end
    mem_ack = 1'b0;
    #1;
    tests++;
    if (bad !== 0) begin
      $display("FAIL store_outputs got %0d bad cycles exp 0", bad); fails++;
    end
    tests++;
    if ({state_dbg, fault} !== 5'b0001_0) begin
      $display("FAIL ack_at_limit got st=%0d fault=%b exp st=1 fault=0",
               state_dbg, fault); fails++;
    end
  endtask

  task automatic test_fault;
    int n;
    int bad;
    n = 0;
    bad = 0;
    mem_ack = 1'b1; mem_rdata = 8'h2C;
    tick;
    mem_ack = 1'b0;
    tick;
    while (state_dbg == 4'd5 && n < 40) begin
      n++;
      tick;
    end
    tests++;
    if (n !== 15) begin
      $display("FAIL timeout_len got %0d exp 15", n); fails++;
    end
    tests++;
    if ({state_dbg, fault, mem_req} !== 6'b0111_10) begin
      $display("FAIL fault_entry got st=%0d f=%b req=%b exp 7 1 0",
               state_dbg, fault, mem_req); fails++;
    end
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1;
      run = i[0];
      tick;
      if ({state_dbg, fault, mem_req} !== 6'b0111_10) bad++;
    end
    tests++;
    if (bad !== 0) begin
      $display("FAIL fault_sticky got %0d bad cycles exp 0", bad); fails++;
    end
    mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({state_dbg, fault} !== 5'b0000_0) begin
      $display("FAIL fault_clear got st=%0d f=%b exp 0 0",
               state_dbg, fault); fails++;
    end
    tick;
    rst = 1'b0;
  endtask

  task automatic test_halt;
    int bad;
    bad = 0;
    run = 1'b1;
    tick;
    mem_ack = 1'b1; mem_rdata = 8'hF0;
    tick;
    mem_ack = 1'b0;
    tick;
    tests++;
    if ({state_dbg, halted, mem_req} !== 6'b0110_10) begin
      $display("FAIL halt_entry got st=%0d h=%b req=%b exp 6 1 0",
               state_dbg, halted, mem_req); fails++;
    end
    for (int i = 0; i < 4; i++) begin
      run = ~run;
      mem_ack = i[0];
      tick;
      if ({state_dbg, halted, mem_req, pc_inc} !== 7'b0110_100) bad++;
    end
    tests++;
    if (bad !== 0) begin
      $display("FAIL halt_sticky got %0d bad cycles exp 0", bad); fails++;
    end
    mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({state_dbg, halted} !== 5'b0000_0) begin
      $display("FAIL halt_clear got st=%0d h=%b exp 0 0",
               state_dbg, halted); fails++;
    end
    tick;
    rst = 1'b0;
  endtask

  task automatic test_rst_async;
    run = 1'b1;
    tick;
    tick;
    tick;
    tests++;
    if ({state_dbg, mem_req} !== 5'b0001_1) begin
      $display("FAIL rst_pre got st=%0d req=%b exp 1 1",
               state_dbg, mem_req); fails++;
    end
    #2;
    mem_ack = 1'b1; mem_rdata = 8'h85;
    rst = 1'b1;
    #1;
    tests++;
    if ({state_dbg, mem_req, pc_inc, operand} !== 10'b0) begin
      $display("FAIL rst_async got st=%0d req=%b inc=%b op=%0h exp all 0",
               state_dbg, mem_req, pc_inc, operand); fails++;
    end
    tick;
    mem_ack = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_ldi;
    test_mem_rd;
    test_jz;
    test_run_drop;
    test_ack_boundary;
    test_fault;
    test_halt;
    test_rst_async;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
